// File: rtl/wallace_mul_pipe.sv
// wallace_mul_pipe: pipelined Wallace-tree multiplier with valid/ready flow
// control, per-operation signed/unsigned mode and a sideband tag.
//
// Pipeline: rank 0 captures the partial-product rows at accept. Ranks
// 1..STAGES share the 3:2 compressor levels and the final carry-propagate
// add, and rank STAGES holds the product. An operation accepted at edge N
// therefore shows out_valid after edge N+STAGES. A single global stall
// freezes every rank while the output is valid and not accepted.
//
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   in_valid/in_ready        input handshake (in_ready = !stall)
//   a, b, is_signed, in_tag  operands, mode (1 = two's complement), tag
//   out_valid/out_ready      output handshake
//   result, out_tag          2*WIDTH-bit product and its tag
module wallace_mul_pipe #(
    parameter int unsigned WIDTH  = 32,
    parameter int unsigned STAGES = 3,
    parameter int unsigned TAG_W  = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [WIDTH-1:0]     a,
    input  logic [WIDTH-1:0]     b,
    input  logic                 is_signed,
    input  logic [TAG_W-1:0]     in_tag,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [2*WIDTH-1:0]   result,
    output logic [TAG_W-1:0]     out_tag
);

    localparam int unsigned PW  = 2 * WIDTH;
    // WIDTH multiplicand rows plus one row for the signed-mode +1 correction
    localparam int unsigned NPP = WIDTH + 1;

    typedef logic [NPP-1:0][PW-1:0] rows_t;

    // Live row count after a given number of 3:2 levels
    function automatic int unsigned rows_after(input int unsigned lvl);
        int unsigned n;
        n = NPP;
        for (int unsigned i = 0; i < lvl; i++) begin
            n = 2 * (n / 3) + (n % 3);
        end
        return n;
    endfunction

    function automatic int unsigned count_levels();
        int unsigned n;
        int unsigned l;
        n = NPP;
        l = 0;
        while (n > 2) begin
            n = 2 * (n / 3) + (n % 3);
            l = l + 1;
        end
        return l;
    endfunction

    localparam int unsigned LEVELS = count_levels();
    // Reduction steps: every compressor level plus the final adder
    localparam int unsigned NRED   = LEVELS + 1;

    // Even split of reduction steps: rank k runs steps [lo(k), hi(k))
    function automatic int unsigned step_lo(input int unsigned k);
        return ((k - 1) * NRED) / STAGES;
    endfunction

    function automatic int unsigned step_hi(input int unsigned k);
        return (k * NRED) / STAGES;
    endfunction

    // Partial products; in signed mode the top row carries negative weight,
    // formed as ~(a<<(W-1)) with the +1 placed in the extra correction row.
    function automatic rows_t pp_gen(input logic [WIDTH-1:0] x,
                                     input logic [WIDTH-1:0] y,
                                     input logic sgn);
        rows_t          r;
        logic [PW-1:0]  x_ext;
        r     = '0;
        x_ext = sgn ? {{WIDTH{x[WIDTH-1]}}, x} : {{WIDTH{1'b0}}, x};
        for (int unsigned i = 0; i < WIDTH; i++) begin
            if (y[i]) begin
                r[i] = (sgn && (i == WIDTH - 1)) ? ((~x_ext) << i) : (x_ext << i);
            end
        end
        r[WIDTH] = (sgn && y[WIDTH-1]) ? (PW'(1) << (WIDTH - 1)) : '0;
        return r;
    endfunction

    // One Wallace level: each group of three rows becomes sum + shifted carry,
    // leftover rows pass through unchanged.
    function automatic rows_t csa_level(input rows_t r, input int unsigned n);
        rows_t        o;
        int unsigned  g3;
        o  = '0;
        g3 = n / 3;
        for (int unsigned g = 0; g < NPP / 3; g++) begin
            if (g < g3) begin
                o[2*g]   = r[3*g] ^ r[3*g+1] ^ r[3*g+2];
                o[2*g+1] = ((r[3*g] & r[3*g+1]) | (r[3*g] & r[3*g+2]) |
                            (r[3*g+1] & r[3*g+2])) << 1;
            end
        end
        for (int unsigned j = 0; j < 2; j++) begin
            if (j < n % 3) begin
                o[2*g3+j] = r[3*g3+j];
            end
        end
        return o;
    endfunction

    // Step s < LEVELS is a compressor level; the last step is the final add
    function automatic rows_t reduce_step(input rows_t r, input int unsigned s);
        rows_t o;
        if (s < LEVELS) begin
            o = csa_level(r, rows_after(s));
        end else begin
            o    = '0;
            o[0] = r[0] + r[1];
        end
        return o;
    endfunction

    logic                 v_q   [STAGES+1];
    logic [TAG_W-1:0]     tag_q [STAGES+1];
    rows_t                rows_q [STAGES];
    rows_t                rows_d [STAGES];
    rows_t                cur;
    logic [PW-1:0]        res_q;
    logic [PW-1:0]        res_d;
    logic                 stall;

    assign stall     = out_valid && !out_ready;
    assign in_ready  = !stall;
    assign out_valid = v_q[STAGES];
    assign out_tag   = tag_q[STAGES];
    assign result    = res_q;

    // Datapath: partial products at the input, reduction steps per rank
    always_comb begin
        for (int unsigned k = 0; k < STAGES; k++) begin
            rows_d[k] = '0;
        end
        res_d = '0;
        cur   = '0;
        rows_d[0] = pp_gen(a, b, is_signed);
        for (int unsigned k = 1; k <= STAGES; k++) begin
            cur = rows_q[k-1];
            for (int unsigned s = 0; s < NRED; s++) begin
                if (s >= step_lo(k) && s < step_hi(k)) begin
                    cur = reduce_step(cur, s);
                end
            end
            if (k < STAGES) begin
                rows_d[k] = cur;
            end else begin
                res_d = cur[0];
            end
        end
    end

    // Stage registers; bubbles advance like valid entries, stall freezes all
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int unsigned k = 0; k <= STAGES; k++) begin
                v_q[k]   <= 1'b0;
                tag_q[k] <= '0;
            end
            for (int unsigned k = 0; k < STAGES; k++) begin
                rows_q[k] <= '0;
            end
            res_q <= '0;
        end else if (!stall) begin
            v_q[0]    <= in_valid;
            tag_q[0]  <= in_tag;
            rows_q[0] <= rows_d[0];
            for (int unsigned k = 1; k <= STAGES; k++) begin
                v_q[k]   <= v_q[k-1];
                tag_q[k] <= tag_q[k-1];
            end
            for (int unsigned k = 1; k < STAGES; k++) begin
                rows_q[k] <= rows_d[k];
            end
            res_q <= res_d;
        end
    end

endmodule
